sem_ctrl_multi: RTL
===================

Name: sem_ctrl_multi

Overview:
- Parametrised multi-channel semaphore (traffic-light) controller with a control slave and a memory slave; successor to the single-channel divider-based controller.
- NCH independent channels step RED -> YEL -> YEL_GRN -> GRN, with per-phase dwell taken from a shared, software-written period table.
- Adds per-channel run, table-bank select, hold/cycle mode, phase status readback and sticky train-event flags.
- Sits between the CPU interconnect (control and memory slaves) and the trackside lamp/train I/O.

Parameters:
- NCH, 4, channel count (1..8).
- CW, 32, period counter and table entry width.
- FLASH_LOG2, 24, log2 of the flash half-period in clk cycles (used only with SEM_FLASH_EN).

Ports:
- clk  in  1  system clock
- clr  in  1  reset: synchronous, active-high
- ctl_wr  in  1  control write strobe
- ctl_rd  in  1  control read strobe (informational; read is combinational)
- ctl_addr  in  3  control register address
- ctl_wrdata  in  32  control write data
- ctl_rddata  out  32  control read data
- ram_wr  in  1  period-table write strobe
- ram_addr  in  4  table index = {bank[1:0], phase[1:0]}
- ram_wrdata  in  CW  table write data
- train  in  NCH  per-channel train-present input
- red, yellow, green  out  NCH each  per-channel lamp drives

Behaviour:
- Only clk is used; all state resets synchronously when clr=1.
- Register map (ctl_addr):
  - 0 RUN[NCH-1:0], RW.
  - 1 BANK: 2 bits per channel, ch i at [2i+1:2i], RW.
  - 2 MODE[NCH-1:0], RW; 0 = hold in GRN, 1 = cycle GRN -> RED.
  - 3 STATUS, RO: phase code per channel at [2i+1:2i].
  - 4 TEVT[NCH-1:0]: sticky train events, write-1-to-clear.
  - Unmapped addresses and unused bits read 0; writes to them are ignored.
- ctl_rddata is combinational from ctl_addr (0 read latency). Register writes take effect on the next clk edge.
- Period table: 16 x CW flops, written when ram_wr=1. Read asynchronously by every channel at {BANK[i], phase[i]}. Resets to all zero.
- Phase codes and lamps {red, yellow, green}: RED=0 (100), YEL=1 (010), YEL_GRN=2 (011), GRN=3 (001).
- Per channel i, each clk:
  - If train[i] or !RUN[i]: cnt<=0, phase<=RED.
  - Else if cnt == period: cnt<=0, advance phase. GRN advances to RED only if MODE[i]=1; otherwise it stays GRN.
  - Else cnt<=cnt+1.
- Dwell per phase is period+1 cycles; period 0 gives a 1-cycle dwell.
- A table write to an in-use entry takes effect on the next compare. A period lowered below the current cnt makes cnt count up through wrap (2^CW) before matching; this is accepted behaviour.
- Lamp outputs are registered from phase: 1-cycle latency from the phase change.
- Reset values: red = all 1s; yellow, green, ctl state, cnt, TEVT = 0; phase = RED.
- TEVT[i] sets on a rising edge of train[i] (train registered once internally). Set wins over a simultaneous W1C.
- Simultaneous train and period match: train wins (RED, cnt=0).

Optional Feature:
- Macro: SEM_FLASH_EN.
- Defined: a channel with RUN=0 and train=0 drives red=0, green=0, and yellow toggling every 2^FLASH_LOG2 cycles from a free-running counter shared by all channels. train=1 still forces solid red.
- Undefined: a stopped channel shows solid red; no flash counter is built.

Decomposition:
- Package sem_pkg:
  - phase_t enum (RED, YEL, YEL_GRN, GRN) and the phase-to-lamp encoding function.
  - Register address localparams REG_RUN..REG_TEVT.
- Sub-module sem_channel:
  - Contains cnt, the phase FSM, lamp register and train edge detect.
  - Instantiated NCH times in a generate loop.
  - Top level holds the control registers, period table, read mux and flash counter.

Test Plan:
- Reset: hold clr=1 for 2 cycles -> red=4'hF, yellow=green=0, all registers read 0.
- Table bank0 = {RED:2, YEL:1, YEL_GRN:0, GRN:3}; write RUN=1 -> ch0 red 3 cycles, yellow 2, yellow+green 1, then green held; STATUS[1:0]=3.
- Same setup with MODE=1 -> ch0 green 4 cycles then red; the sequence repeats with period 10 cycles.
- Assert train[0] for 1 cycle while ch0 is GRN -> red on the following lamp update; TEVT reads 1; writing 1 to addr 4 clears it; a coincident new edge keeps it 1.
- ch1 BANK=2 with entries 8..11 = 5, RUN=3'b011 -> ch0 and ch1 step independently; ch1 dwell is 6 cycles per phase.
- SEM_FLASH_EN with FLASH_LOG2=2, RUN=0 -> yellow toggles every 4 cycles, red=0; train=1 -> solid red.

Source files
------------

// File: rtl/sem_ctrl_multi_pkg.sv
// Shared types and constants for the multi-channel semaphore controller.
// Optional build macro SEM_FLASH_EN (see sem_ctrl_multi / sem_channel).
package sem_pkg;

  typedef enum logic [1:0] {
    RED     = 2'd0,
    YEL     = 2'd1,
    YEL_GRN = 2'd2,
    GRN     = 2'd3
  } phase_t;

  localparam logic [2:0] REG_RUN    = 3'd0;
  localparam logic [2:0] REG_BANK   = 3'd1;
  localparam logic [2:0] REG_MODE   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_TEVT   = 3'd4;

  // Lamp drive {red, yellow, green} shown for each phase.
  function automatic logic [2:0] phaseLamps(input phase_t p);
    logic [2:0] lamps;
    case (p)
      RED:     lamps = 3'b100;
      YEL:     lamps = 3'b010;
      YEL_GRN: lamps = 3'b011;
      GRN:     lamps = 3'b001;
      default: lamps = 3'b100;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/sem_ctrl_multi_channel.sv
// One semaphore channel: dwell counter, phase FSM, registered lamps and
// train rising-edge detect. With SEM_FLASH_EN a stopped, train-free
// channel flashes yellow from the shared flash level instead of red.
module sem_channel
  import sem_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run_i,
  input  logic          mode_i,
  input  logic          train_i,
  input  logic          flash_i,
  input  logic [CW-1:0] period_i,
  output phase_t        phase_o,
  output logic          trainRise_o,
  output logic          red_o,
  output logic          yellow_o,
  output logic          green_o
);

  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          train_q;
  logic [2:0]    lamps_q, lamps_d;

  // Train or a stopped channel pins the channel to RED; otherwise count the dwell and step the phase on a match.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + CW'(1);
    if (train_i || !run_i) begin
      phase_d = RED;
      cnt_d   = '0;
    end else if (cnt_q == period_i) begin
      cnt_d = '0;
      case (phase_q)
        RED:     phase_d = YEL;
        YEL:     phase_d = YEL_GRN;
        YEL_GRN: phase_d = GRN;
        GRN:     phase_d = mode_i ? RED : GRN;
        default: phase_d = RED;
      endcase
    end
  end

  // Lamps follow the current phase, so they lag a phase change by one clock.
  always_comb begin
    lamps_d = phaseLamps(phase_q);
`ifdef SEM_FLASH_EN
    if (!run_i && !train_i) begin
      lamps_d = {1'b0, flash_i, 1'b0};
    end
`endif
  end

`ifndef SEM_FLASH_EN
  logic unusedFlash;
  assign unusedFlash = flash_i;
`endif

  // State, lamp and train-history registers with synchronous reset to a red light.
  always_ff @(posedge clk) begin
    if (clr) begin
      phase_q <= RED;
      cnt_q   <= '0;
      train_q <= 1'b0;
      lamps_q <= 3'b100;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      train_q <= train_i;
      lamps_q <= lamps_d;
    end
  end

  assign phase_o     = phase_q;
  assign trainRise_o = train_i & ~train_q;
  assign red_o       = lamps_q[2];
  assign yellow_o    = lamps_q[1];
  assign green_o     = lamps_q[0];

endmodule

// File: rtl/sem_ctrl_multi.sv
// Multi-channel semaphore controller: control registers, 16-entry period
// table, combinational read mux and NCH channel instances.
// Optional build macro SEM_FLASH_EN adds a shared yellow flash counter.
module sem_ctrl_multi
  import sem_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = 32,
  parameter int FLASH_LOG2 = 24
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           ctl_wr,
  input  logic           ctl_rd,
  input  logic [2:0]     ctl_addr,
  input  logic [31:0]    ctl_wrdata,
  output logic [31:0]    ctl_rddata,
  input  logic           ram_wr,
  input  logic [3:0]     ram_addr,
  input  logic [CW-1:0]  ram_wrdata,
  input  logic [NCH-1:0] train,
  output logic [NCH-1:0] red,
  output logic [NCH-1:0] yellow,
  output logic [NCH-1:0] green
);

  logic [NCH-1:0]   run_q;
  logic [NCH-1:0]   mode_q;
  logic [2*NCH-1:0] bank_q;
  logic [NCH-1:0]   tevt_q, tevt_d;
  logic [NCH-1:0]   trainRise;
  logic [2*NCH-1:0] status;
  logic [CW-1:0]    table_q [16];
  phase_t           phase [NCH];
  logic             flash;

  // Reads are combinational and only the ctl_rd strobe is informational.
  logic unusedCtl;
  assign unusedCtl = ^{ctl_rd, ctl_wrdata};

  // Sticky train events: clear the written ones, but a new edge in the same cycle wins.
  always_comb begin
    tevt_d = tevt_q;
    if (ctl_wr && (ctl_addr == REG_TEVT)) begin
      tevt_d = tevt_d & ~ctl_wrdata[NCH-1:0];
    end
    tevt_d = tevt_d | trainRise;
  end

  // Control registers; writes to unmapped or read-only addresses fall through.
  always_ff @(posedge clk) begin
    if (clr) begin
      run_q  <= '0;
      mode_q <= '0;
      bank_q <= '0;
      tevt_q <= '0;
    end else begin
      tevt_q <= tevt_d;
      if (ctl_wr) begin
        case (ctl_addr)
          REG_RUN:  run_q  <= ctl_wrdata[NCH-1:0];
          REG_BANK: bank_q <= ctl_wrdata[2*NCH-1:0];
          REG_MODE: mode_q <= ctl_wrdata[NCH-1:0];
          default:  ;
        endcase
      end
    end
  end

  // Period table: plain flops so every channel can look it up at once.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 16; k++) begin
        table_q[k] <= '0;
      end
    end else if (ram_wr) begin
      table_q[ram_addr] <= ram_wrdata;
    end
  end

  // Register read mux, zero-filled above the implemented bits.
  always_comb begin
    ctl_rddata = '0;
    case (ctl_addr)
      REG_RUN:    ctl_rddata[NCH-1:0]   = run_q;
      REG_BANK:   ctl_rddata[2*NCH-1:0] = bank_q;
      REG_MODE:   ctl_rddata[NCH-1:0]   = mode_q;
      REG_STATUS: ctl_rddata[2*NCH-1:0] = status;
      REG_TEVT:   ctl_rddata[NCH-1:0]   = tevt_q;
      default:    ;
    endcase
  end

`ifdef SEM_FLASH_EN
  logic [FLASH_LOG2:0] flashCnt_q;

  // Free-running counter whose top bit is the shared yellow flash level.
  always_ff @(posedge clk) begin
    if (clr) begin
      flashCnt_q <= '0;
    end else begin
      flashCnt_q <= flashCnt_q + 1'b1;
    end
  end

  assign flash = flashCnt_q[FLASH_LOG2];
`else
  localparam int unusedFlashLog2 = FLASH_LOG2;
  assign flash = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : gCh
    logic [3:0] tableIdx;
    assign tableIdx = {bank_q[2*g+:2], phase[g]};

    sem_channel #(
      .CW(CW)
    ) uChannel (
      .clk         (clk),
      .clr         (clr),
      .run_i       (run_q[g]),
      .mode_i      (mode_q[g]),
      .train_i     (train[g]),
      .flash_i     (flash),
      .period_i    (table_q[tableIdx]),
      .phase_o     (phase[g]),
      .trainRise_o (trainRise[g]),
      .red_o       (red[g]),
      .yellow_o    (yellow[g]),
      .green_o     (green[g])
    );

    assign status[2*g+:2] = phase[g];
  end

endmodule
